flexbex_ibex_regfile_sb: RTL and testbench

Parametrised successor register file for the flexbex ibex core. Adds a configurable number of read ports, a second write port for long-latency (LSU / multi-cycle) writeback, optional same-cycle write-to-read bypass, and a per-register pending scoreboard. The decoder uses the scoreboard to stall on load-use hazards. Sits between the ID stage (reads, lock) and the EX/LSU writeback paths (write ports A and B).

---
 rtl/flexbex_ibex_regfile_sb.sv | 95 +++++++++
 tb/tb_flexbex_ibex_regfile_sb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_ibex_regfile_sb.sv
// flexbex_ibex_regfile_sb: multi-port register file with pending scoreboard.
// Two write ports (A: ALU, B: LSU), optional write-to-read bypass.
module flexbex_ibex_regfile_sb #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter bit          BYPASS       = 1'b1,
  localparam int unsigned NUM_WORDS   = RV32E ? 16 : 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [5*NUM_RD_PORTS-1:0]          raddr_i,
  output logic [DATA_WIDTH*NUM_RD_PORTS-1:0] rdata_o,
  output logic [NUM_RD_PORTS-1:0]            rbusy_o,
  input  logic                               we_a_i,
  input  logic [4:0]                         waddr_a_i,
  input  logic [DATA_WIDTH-1:0]              wdata_a_i,
  input  logic                               we_b_i,
  input  logic [4:0]                         waddr_b_i,
  input  logic [DATA_WIDTH-1:0]              wdata_b_i,
  input  logic                               lock_i,
  input  logic [4:0]                         lock_addr_i,
  output logic [NUM_WORDS-1:0]               busy_vec_o
);

  localparam int unsigned AW = RV32E ? 4 : 5;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                mem [NUM_WORDS];
  logic [NUM_WORDS-1:0] busy;
  logic [NUM_WORDS-1:0] hit_a;
  logic [NUM_WORDS-1:0] hit_b;
  logic [NUM_WORDS-1:0] hit_l;

  // Entry 0 never hits, and illegal RV32E addresses never match an entry.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    hit_l = '0;
    for (int unsigned r = 1; r < NUM_WORDS; r++) begin
      hit_a[r] = we_a_i && (waddr_a_i == 5'(r));
      hit_b[r] = we_b_i && (waddr_b_i == 5'(r));
      hit_l[r] = lock_i && (lock_addr_i == 5'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_WORDS; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_WORDS; r++) begin
        if (hit_a[r]) begin
          mem[r] <= wdata_a_i;
        end else if (hit_b[r]) begin
          mem[r] <= wdata_b_i;
        end
        // A dropped B write does not retire the pending op.
        busy[r] <= hit_l[r] | (busy[r] & ~(hit_b[r] & ~hit_a[r]));
      end
    end
  end

  assign busy_vec_o = busy;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [4:0]    addr;
    logic [AW-1:0] idx;
    logic          legal;
    logic          byp;
    logic          ma;
    logic          mb;
    logic          ml;

    assign addr  = raddr_i[5*p +: 5];
    assign idx   = addr[AW-1:0];
    assign legal = (addr != 5'd0) && !(RV32E && addr[4]);
    assign byp   = BYPASS && rst_n && legal;
    assign ma    = byp && we_a_i && (waddr_a_i == addr);
    assign mb    = byp && we_b_i && (waddr_b_i == addr);
    assign ml    = lock_i && (lock_addr_i == addr);

    assign rdata_o[DATA_WIDTH*p +: DATA_WIDTH] =
      !legal ? '0        :
      ma     ? wdata_a_i :
      mb     ? wdata_b_i :
               mem[idx];

    assign rbusy_o[p] = legal && busy[idx] && !(mb && !ml);
  end

endmodule

// File: tb/tb_flexbex_ibex_regfile_sb.sv
// Bench for flexbex_ibex_regfile_sb: three configs share the write bus.
// Reference model predicts reads; expectations queued then compared.
module tb_flexbex_ibex_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_a, we_b, lock;
  logic [4:0]  wa, wb, la;
  logic [31:0] wda, wdb;
  logic [9:0]  ra01;
  logic [19:0] ra2;

  logic [63:0]  rd0, rd1;
  logic [127:0] rd2;
  logic [1:0]   rb0, rb1;
  logic [3:0]   rb2;
  logic [31:0]  bv0, bv1;
  logic [15:0]  bv2;

  always #5 clk = ~clk;

  flexbex_ibex_regfile_sb #(
    .RV32E(1'b0), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .BYPASS(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .raddr_i(ra01), .rdata_o(rd0),
    .rbusy_o(rb0), .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
    .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb), .lock_i(lock),
    .lock_addr_i(la), .busy_vec_o(bv0)
  );

  flexbex_ibex_regfile_sb #(
    .RV32E(1'b0), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .BYPASS(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .raddr_i(ra01), .rdata_o(rd1),
    .rbusy_o(rb1), .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
    .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb), .lock_i(lock),
    .lock_addr_i(la), .busy_vec_o(bv1)
  );

  flexbex_ibex_regfile_sb #(
    .RV32E(1'b1), .DATA_WIDTH(32), .NUM_RD_PORTS(4), .BYPASS(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .raddr_i(ra2), .rdata_o(rd2),
    .rbusy_o(rb2), .we_a_i(we_a), .waddr_a_i(wa), .wdata_a_i(wda),
    .we_b_i(we_b), .waddr_b_i(wb), .wdata_b_i(wdb), .lock_i(lock),
    .lock_addr_i(la), .busy_vec_o(bv2)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] m_reg  [3][32];
  bit          m_busy [3][32];
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};
  bit          e32 [3] = '{1'b0, 1'b0, 1'b1};
  int          np  [3] = '{2, 2, 4};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(int k, logic [4:0] a);
    return (a != 5'd0) && !(e32[k] && a[4]);
  endfunction

  function automatic logic [4:0] raddr(int k, int p);
    return (k < 2) ? ra01[5*p +: 5] : ra2[5*p +: 5];
  endfunction

  function automatic logic [31:0] obs(int sel);
    int k, kind, p;
    k    = sel / 16;
    kind = (sel / 4) % 4;
    p    = sel % 4;
    case (kind)
      0: return (k == 0) ? rd0[32*p +: 32] :
                (k == 1) ? rd1[32*p +: 32] : rd2[32*p +: 32];
      1: return (k == 0) ? 32'(rb0[p]) :
                (k == 1) ? 32'(rb1[p]) : 32'(rb2[p]);
      default: return (k == 0) ? bv0 : (k == 1) ? bv1 : 32'(bv2);
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  task automatic push();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] vec;
      bit bp;
      bp = byp[k] && rst_n;
      for (int p = 0; p < np[k]; p++) begin
        logic [4:0]  a;
        logic [31:0] ed;
        bit          eb;
        a  = raddr(k, p);
        ed = '0;
        eb = 1'b0;
        if (legal(k, a)) begin
          ed = m_reg[k][a];
          eb = m_busy[k][a];
          if (bp && we_a && wa == a) ed = wda;
          else if (bp && we_b && wb == a) ed = wdb;
          if (bp && we_b && wb == a && !(lock && la == a)) eb = 1'b0;
        end
        q.push_back('{$sformatf("u%0d rd%0d x%0d", k, p, a), k*16 + p, ed});
        q.push_back('{$sformatf("u%0d rb%0d x%0d", k, p, a),
                      k*16 + 4 + p, 32'(eb)});
      end
      vec = '0;
      for (int r = 0; r < (e32[k] ? 16 : 32); r++) vec[r] = m_busy[k][r];
      q.push_back('{$sformatf("u%0d bvec", k), k*16 + 8, vec});
    end
  endtask

  task automatic drain();
    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      check(x.tag, obs(x.sel), x.exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (we_a && legal(k, wa)) m_reg[k][wa] = wda;
      if (we_b && legal(k, wb) && !(we_a && wa == wb)) begin
        m_reg[k][wb]  = wdb;
        m_busy[k][wb] = 1'b0;
      end
      if (lock && legal(k, la)) m_busy[k][la] = 1'b1;
    end
  endtask

  // Entered just after a rising edge with inputs already driven.
  task automatic step();
    push();
    #3;
    drain();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; lock = 1'b0;
    wa = '0; wb = '0; la = '0; wda = '0; wdb = '0;
  endtask

  task automatic rd_all(logic [4:0] a);
    ra01 = {a, a};
    ra2  = {a, a, a, a};
  endtask

  task automatic wr_a(logic [4:0] a, logic [31:0] d);
    we_a = 1'b1; wa = a; wda = d;
  endtask

  task automatic wr_b(logic [4:0] a, logic [31:0] d);
    we_b = 1'b1; wb = a; wdb = d;
  endtask

  task automatic lk(logic [4:0] a);
    lock = 1'b1; la = a;
  endtask

  initial begin
    idle();
    rd_all(5'd0);
    model_clear();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd_all(5'd9);
    step();
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      rd_all(5'(a));
      step();
    end

    wr_a(5'd0, 32'hDEADBEEF); rd_all(5'd0); step();
    idle(); step();
    check("x0 after write", rd0[31:0], 32'h0);

    wr_a(5'd5, 32'h12345678); rd_all(5'd5); step();
    idle(); #1;
    check("x5 u0", rd0[31:0], 32'h12345678);
    check("x5 u1", rd1[63:32], 32'h12345678);
    step();

    idle(); wr_a(5'd7, 32'hA); wr_b(5'd7, 32'hB); rd_all(5'd7); step();
    idle(); lk(5'd7); step();
    idle(); wr_a(5'd7, 32'hA); wr_b(5'd7, 32'hB); step();
    idle(); #1;
    check("x7 collide", rd1[31:0], 32'hA);
    check("x7 busy", 32'(rb0[0]), 32'h1);
    step();

    lk(5'd9); rd_all(5'd9); step();
    idle(); #1;
    check("x9 lock", 32'(bv0[9]), 32'h1);
    step();
    wr_a(5'd9, 32'h77); step();
    idle(); wr_b(5'd9, 32'h55); step();
    idle(); #1;
    check("x9 unlock", 32'(bv1[9]), 32'h0);
    step();
    lk(5'd9); step();
    idle(); lk(5'd9); wr_b(5'd9, 32'h66); step();
    idle(); step();

    wr_a(5'd20, 32'hCAFE0020); lk(5'd20); rd_all(5'd20); step();
    idle(); step();
    for (int r = 1; r <= 4; r++) begin
      wr_a(5'(r), 32'h1000 + 32'(r));
      wr_b(5'(r + 16), 32'hB000 + 32'(r));
      step();
    end
    idle();
    ra2 = {5'd4, 5'd3, 5'd2, 5'd1};
    ra01 = {5'd2, 5'd1};
    step();
    check("e x3", rd2[95:64], 32'h1003);

    for (int i = 0; i < 400; i++) begin
      we_a = 1'($urandom);
      we_b = 1'($urandom);
      lock = 1'($urandom_range(0, 3) == 0);
      wa   = 5'($urandom);
      wb   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      la   = ($urandom_range(0, 3) == 0) ? wb : 5'($urandom);
      wda  = $urandom;
      wdb  = $urandom;
      ra01 = {($urandom_range(0, 1) != 0) ? wb : 5'($urandom), 5'($urandom)};
      ra2  = 20'($urandom);
      if ($urandom_range(0, 2) == 0) ra2[4:0] = wa;
      step();
    end

    idle(); lk(5'd3); rd_all(5'd3); step();
    idle(); wr_a(5'd3, 32'h33); step();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst bvec", bv0, 32'h0);
    wr_a(5'd3, 32'h99);
    step();
    idle(); step();
    rst_n = 1'b1;
    step();
    lk(5'd6); rd_all(5'd6); step();
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
